// File: rtl/ahb2axi_pkg.sv
// Shared AHB-Lite / AXI encodings and the bridge state type.
package ahb2axi_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      HBURST_SINGLE, HBURST_INCR, HBURST_WRAP4, HBURST_INCR4,
      HBURST_WRAP8, HBURST_INCR8, HBURST_WRAP16, HBURST_INCR16
   } hburst_t;

   typedef enum logic [2:0] {
      HSIZE_8, HSIZE_16, HSIZE_32, HSIZE_64,
      HSIZE_128, HSIZE_256, HSIZE_512, HSIZE_1024
   } hsize_t;

   typedef enum logic {
      HRESP_OKAY  = 1'b0,
      HRESP_ERROR = 1'b1
   } hresp_t;

   typedef enum logic [3:0] {
      S_IDLE, S_WR_DATA, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_DATA, S_DONE, S_ERR1, S_ERR2
   } ahb2axi_state_t;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/ahb2axi_if.sv
// AHB-Lite slave port and AXI master port bundles used by the bridge.
interface ahb_if #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ADDR_W = 32
);
   logic              HSEL;
   logic [ADDR_W-1:0] HADDR;
   logic [1:0]        HTRANS;
   logic              HWRITE;
   logic [2:0]        HSIZE;
   logic [2:0]        HBURST;
   logic [DATA_W-1:0] HWDATA;
   logic              HREADY;
   logic              HREADYOUT;
   logic              HRESP;
   logic [DATA_W-1:0] HRDATA;

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
      input  HREADYOUT, HRESP, HRDATA
   );
   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
      output HREADYOUT, HRESP, HRDATA
   );
endinterface

interface axi_if #(
   parameter int unsigned ID_W   = 1,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 64
);
   logic [ID_W-1:0]     axi_aw_id_o;
   logic [ADDR_W-1:0]   axi_aw_addr_o;
   logic [7:0]          axi_aw_len_o;
   logic [2:0]          axi_aw_size_o;
   logic [1:0]          axi_aw_burst_o;
   logic                axi_aw_lock_o;
   logic [3:0]          axi_aw_cache_o;
   logic [2:0]          axi_aw_prot_o;
   logic [3:0]          axi_aw_qos_o;
   logic [3:0]          axi_aw_region_o;
   logic                axi_aw_user_o;
   logic                axi_aw_valid_o;
   logic                axi_aw_ready_i;

   logic [DATA_W-1:0]   axi_w_data_o;
   logic [DATA_W/8-1:0] axi_w_strb_o;
   logic                axi_w_last_o;
   logic                axi_w_user_o;
   logic                axi_w_valid_o;
   logic                axi_w_ready_i;

   logic [ID_W-1:0]     axi_b_id_i;
   logic [1:0]          axi_b_resp_i;
   logic                axi_b_valid_i;
   logic                axi_b_ready_o;

   logic [ID_W-1:0]     axi_ar_id_o;
   logic [ADDR_W-1:0]   axi_ar_addr_o;
   logic [7:0]          axi_ar_len_o;
   logic [2:0]          axi_ar_size_o;
   logic [1:0]          axi_ar_burst_o;
   logic                axi_ar_lock_o;
   logic [3:0]          axi_ar_cache_o;
   logic [2:0]          axi_ar_prot_o;
   logic [3:0]          axi_ar_qos_o;
   logic [3:0]          axi_ar_region_o;
   logic                axi_ar_user_o;
   logic                axi_ar_valid_o;
   logic                axi_ar_ready_i;

   logic [ID_W-1:0]     axi_r_id_i;
   logic [DATA_W-1:0]   axi_r_data_i;
   logic [1:0]          axi_r_resp_i;
   logic                axi_r_last_i;
   logic                axi_r_valid_i;
   logic                axi_r_ready_o;

   modport master (
      output axi_aw_id_o, axi_aw_addr_o, axi_aw_len_o, axi_aw_size_o, axi_aw_burst_o,
             axi_aw_lock_o, axi_aw_cache_o, axi_aw_prot_o, axi_aw_qos_o, axi_aw_region_o,
             axi_aw_user_o, axi_aw_valid_o,
             axi_w_data_o, axi_w_strb_o, axi_w_last_o, axi_w_user_o, axi_w_valid_o,
             axi_b_ready_o,
             axi_ar_id_o, axi_ar_addr_o, axi_ar_len_o, axi_ar_size_o, axi_ar_burst_o,
             axi_ar_lock_o, axi_ar_cache_o, axi_ar_prot_o, axi_ar_qos_o, axi_ar_region_o,
             axi_ar_user_o, axi_ar_valid_o,
             axi_r_ready_o,
      input  axi_aw_ready_i, axi_w_ready_i,
             axi_b_id_i, axi_b_resp_i, axi_b_valid_i,
             axi_ar_ready_i,
             axi_r_id_i, axi_r_data_i, axi_r_resp_i, axi_r_last_i, axi_r_valid_i
   );
   modport slave (
      input  axi_aw_id_o, axi_aw_addr_o, axi_aw_len_o, axi_aw_size_o, axi_aw_burst_o,
             axi_aw_lock_o, axi_aw_cache_o, axi_aw_prot_o, axi_aw_qos_o, axi_aw_region_o,
             axi_aw_user_o, axi_aw_valid_o,
             axi_w_data_o, axi_w_strb_o, axi_w_last_o, axi_w_user_o, axi_w_valid_o,
             axi_b_ready_o,
             axi_ar_id_o, axi_ar_addr_o, axi_ar_len_o, axi_ar_size_o, axi_ar_burst_o,
             axi_ar_lock_o, axi_ar_cache_o, axi_ar_prot_o, axi_ar_qos_o, axi_ar_region_o,
             axi_ar_user_o, axi_ar_valid_o,
             axi_r_ready_o,
      output axi_aw_ready_i, axi_w_ready_i,
             axi_b_id_i, axi_b_resp_i, axi_b_valid_i,
             axi_ar_ready_i,
             axi_r_id_i, axi_r_data_i, axi_r_resp_i, axi_r_last_i, axi_r_valid_i
   );
endinterface

// File: rtl/ahb2axi_wstrb_gen.sv
// Byte-lane strobe from transfer size and the address offset within the data bus.
module axi_wstrb_gen #(
   parameter  int unsigned DW    = 64,
   localparam int unsigned STRBW = DW / 8,
   localparam int unsigned OFFW  = $clog2(STRBW)
) (
   input  logic [2:0]       size,
   input  logic [OFFW-1:0]  offset,
   output logic [STRBW-1:0] strb
);

   int unsigned lo;
   int unsigned hi;

   // Lanes past the top of the bus are dropped, matching a truncated shift.
   always_comb begin
      strb = '0;
      lo   = 32'(offset);
      hi   = lo + (32'd1 << size);
      for (int unsigned i = 0; i < STRBW; i++) begin
         if (i >= lo && i < hi) strb[i] = 1'b1;
      end
   end

endmodule

// File: rtl/ahb2axi.sv
// AHB-Lite slave to AXI master bridge: each AHB beat becomes one single-beat AXI
// transaction, with wait states on HREADYOUT until the AXI response returns.
module ahb2axi
   import ahb2axi_pkg::*;
#(
   parameter int unsigned AHB_DATA_WIDTH    = 64,
   parameter int unsigned AHB_ADDRESS_WIDTH = 32,
   parameter int unsigned TIDW              = 1,
   parameter int unsigned AW                = 32,
   parameter int unsigned DW                = 64,
   parameter int unsigned AXI_ID            = 0
) (
   input logic  HCLK,
   input logic  HRESET,
   ahb_if.slave ahb,
   axi_if.master axi
);

   localparam int unsigned STRBW = DW / 8;
   localparam int unsigned OFFW  = $clog2(STRBW);

   ahb2axi_state_t               state_q, state_d;
   logic [AHB_ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic                         write_q, write_d;
   logic [2:0]                   size_q, size_d;
   logic [DW-1:0]                wdata_q, wdata_d;
   logic [STRBW-1:0]             wstrb_q, wstrb_d;
   logic [AHB_DATA_WIDTH-1:0]    rdata_q, rdata_d;
   logic                         hready_q, hready_d;
   logic                         hresp_q, hresp_d;
   logic                         aw_valid_q, aw_valid_d;
   logic                         w_valid_q, w_valid_d;
   logic                         b_ready_q, b_ready_d;
   logic                         ar_valid_q, ar_valid_d;
   logic                         r_ready_q, r_ready_d;

   logic             accept;
   logic [STRBW-1:0] strb_calc;
   logic             unused_in;

   assign accept = ahb.HSEL && ahb.HREADY && ahb.HTRANS[1];

   // Burst type, IDs and the low response bits carry no meaning for this bridge.
   assign unused_in = ^{ahb.HBURST, ahb.HTRANS[0], axi.axi_b_id_i, axi.axi_r_id_i,
                        axi.axi_r_last_i, axi.axi_b_resp_i[0], axi.axi_r_resp_i[0], write_q};

   axi_wstrb_gen #(.DW(DW)) u_wstrb (
      .size   (size_q),
      .offset (addr_q[OFFW-1:0]),
      .strb   (strb_calc)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      write_d = write_q;
      size_d  = size_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      rdata_d = rdata_q;

      if (accept) begin
         addr_d  = ahb.HADDR;
         write_d = ahb.HWRITE;
         size_d  = ahb.HSIZE;
      end

      unique case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (accept) begin
               if (ahb.HSIZE > 3'(OFFW)) state_d = S_ERR1;
               else if (ahb.HWRITE)      state_d = S_WR_DATA;
               else                      state_d = S_RD_REQ;
            end
         end
         S_WR_DATA: begin
            wdata_d = ahb.HWDATA;
            wstrb_d = strb_calc;
            state_d = S_WR_REQ;
         end
         S_WR_REQ: begin
            if ((!aw_valid_q || axi.axi_aw_ready_i) && (!w_valid_q || axi.axi_w_ready_i))
               state_d = S_WR_RESP;
         end
         S_WR_RESP: begin
            if (axi.axi_b_valid_i) state_d = axi.axi_b_resp_i[1] ? S_ERR1 : S_DONE;
         end
         S_RD_REQ: begin
            if (axi.axi_ar_ready_i) state_d = S_RD_DATA;
         end
         S_RD_DATA: begin
            if (axi.axi_r_valid_i) begin
               rdata_d = axi.axi_r_data_i;
               state_d = axi.axi_r_resp_i[1] ? S_ERR1 : S_DONE;
            end
         end
         S_ERR1:  state_d = S_ERR2;
         S_ERR2:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they leave the flops cleanly.
      aw_valid_d = (state_q == S_WR_DATA) ||
                   (state_q == S_WR_REQ && aw_valid_q && !axi.axi_aw_ready_i);
      w_valid_d  = (state_q == S_WR_DATA) ||
                   (state_q == S_WR_REQ && w_valid_q && !axi.axi_w_ready_i);
      b_ready_d  = (state_d == S_WR_RESP);
      ar_valid_d = (state_d == S_RD_REQ);
      r_ready_d  = (state_d == S_RD_DATA);
      hready_d   = state_d inside {S_IDLE, S_DONE, S_ERR2};
      hresp_d    = state_d inside {S_ERR1, S_ERR2};
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         write_q    <= 1'b0;
         size_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         rdata_q    <= '0;
         hready_q   <= 1'b1;
         hresp_q    <= HRESP_OKAY;
         aw_valid_q <= 1'b0;
         w_valid_q  <= 1'b0;
         b_ready_q  <= 1'b0;
         ar_valid_q <= 1'b0;
         r_ready_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         write_q    <= write_d;
         size_q     <= size_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         rdata_q    <= rdata_d;
         hready_q   <= hready_d;
         hresp_q    <= hresp_d;
         aw_valid_q <= aw_valid_d;
         w_valid_q  <= w_valid_d;
         b_ready_q  <= b_ready_d;
         ar_valid_q <= ar_valid_d;
         r_ready_q  <= r_ready_d;
      end
   end

   assign ahb.HREADYOUT = hready_q;
   assign ahb.HRESP     = hresp_q;
   assign ahb.HRDATA    = rdata_q;

   assign axi.axi_aw_id_o     = TIDW'(AXI_ID);
   assign axi.axi_aw_addr_o   = AW'(addr_q);
   assign axi.axi_aw_len_o    = '0;
   assign axi.axi_aw_size_o   = size_q;
   assign axi.axi_aw_burst_o  = AXI_BURST_INCR;
   assign axi.axi_aw_lock_o   = 1'b0;
   assign axi.axi_aw_cache_o  = '0;
   assign axi.axi_aw_prot_o   = '0;
   assign axi.axi_aw_qos_o    = '0;
   assign axi.axi_aw_region_o = '0;
   assign axi.axi_aw_user_o   = 1'b0;
   assign axi.axi_aw_valid_o  = aw_valid_q;

   assign axi.axi_w_data_o    = wdata_q;
   assign axi.axi_w_strb_o    = wstrb_q;
   assign axi.axi_w_last_o    = 1'b1;
   assign axi.axi_w_user_o    = 1'b0;
   assign axi.axi_w_valid_o   = w_valid_q;

   assign axi.axi_b_ready_o   = b_ready_q;

   assign axi.axi_ar_id_o     = TIDW'(AXI_ID);
   assign axi.axi_ar_addr_o   = AW'(addr_q);
   assign axi.axi_ar_len_o    = '0;
   assign axi.axi_ar_size_o   = size_q;
   assign axi.axi_ar_burst_o  = AXI_BURST_INCR;
   assign axi.axi_ar_lock_o   = 1'b0;
   assign axi.axi_ar_cache_o  = '0;
   assign axi.axi_ar_prot_o   = '0;
   assign axi.axi_ar_qos_o    = '0;
   assign axi.axi_ar_region_o = '0;
   assign axi.axi_ar_user_o   = 1'b0;
   assign axi.axi_ar_valid_o  = ar_valid_q;

   assign axi.axi_r_ready_o   = r_ready_q;

endmodule

// File: tb/tb_ahb2axi.sv
// Directed cycle-exact bench for ahb2axi: single AHB master, reactive AXI target.
module tb_ahb2axi;
   import ahb2axi_pkg::*;

   localparam int unsigned DW   = 64;
   localparam int unsigned AW   = 32;
   localparam int unsigned TIDW = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   ahb_if #(.DATA_W(DW), .ADDR_W(AW)) ahb ();
   axi_if #(.ID_W(TIDW), .ADDR_W(AW), .DATA_W(DW)) axi ();

   // Only slave on the bus, so the bus ready is its own ready.
   assign ahb.HREADY = ahb.HREADYOUT;

   ahb2axi #(
      .AHB_DATA_WIDTH(DW), .AHB_ADDRESS_WIDTH(AW), .TIDW(TIDW),
      .AW(AW), .DW(DW), .AXI_ID(0)
   ) dut (
      .HCLK   (clk),
      .HRESET (rst),
      .ahb    (ahb),
      .axi    (axi)
   );

   always #5 clk = ~clk;

   logic [4:0] hs;
   logic [1:0] ah;
   assign hs = {axi.axi_aw_valid_o, axi.axi_w_valid_o, axi.axi_b_ready_o,
                axi.axi_ar_valid_o, axi.axi_r_ready_o};
   assign ah = {ahb.HREADYOUT, ahb.HRESP};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      ahb.HSEL   = 1'b0;
      ahb.HTRANS = HTRANS_IDLE;
      ahb.HWRITE = 1'b0;
      ahb.HADDR  = '0;
      ahb.HSIZE  = '0;
      ahb.HBURST = HBURST_SINGLE;
   endtask

   task automatic addr_phase(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                             input logic [1:0] tr);
      ahb.HSEL   = 1'b1;
      ahb.HTRANS = tr;
      ahb.HWRITE = wr;
      ahb.HADDR  = a;
      ahb.HSIZE  = sz;
      ahb.HBURST = HBURST_INCR4;
   endtask

   task automatic test_reset();
      bus_idle();
      ahb.HWDATA = '0;
      axi.axi_aw_ready_i = 1'b1; axi.axi_w_ready_i = 1'b1; axi.axi_ar_ready_i = 1'b1;
      axi.axi_b_valid_i = 1'b0;  axi.axi_b_resp_i = AXI_RESP_OKAY; axi.axi_b_id_i = '0;
      axi.axi_r_valid_i = 1'b0;  axi.axi_r_resp_i = AXI_RESP_OKAY; axi.axi_r_id_i = '0;
      axi.axi_r_data_i = '0;     axi.axi_r_last_i = 1'b0;
      rst = 1'b1;
      step(); step();
      checks++; if (ah !== 2'b10) begin failures++; $display("FAIL rst_ah got=%b exp=10", ah); end
      checks++; if (hs !== 5'b0) begin failures++; $display("FAIL rst_valids got=%b exp=00000", hs); end
      checks++; if (ahb.HRDATA !== 64'h0) begin failures++; $display("FAIL rst_hrdata got=%h exp=0", ahb.HRDATA); end
      checks++; if (axi.axi_aw_addr_o !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", axi.axi_aw_addr_o); end
      checks++; if (axi.axi_w_strb_o !== 8'h0) begin failures++; $display("FAIL rst_strb got=%h exp=0", axi.axi_w_strb_o); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_single_write();
      addr_phase(32'h100, 1'b1, 3'd3, HTRANS_NONSEQ);
      checks++; if (ah !== 2'b10) begin failures++; $display("FAIL wr_n_ah got=%b exp=10", ah); end
      step(); // N+1
      bus_idle();
      ahb.HWDATA = 64'hDEADBEEF_CAFEF00D;
      checks++; if (ah !== 2'b00) begin failures++; $display("FAIL wr_n1_ah got=%b exp=00", ah); end
      checks++; if (hs !== 5'b00000) begin failures++; $display("FAIL wr_n1_hs got=%b exp=00000", hs); end
      step(); // N+2
      ahb.HWDATA = '0;
      checks++; if (hs !== 5'b11000) begin failures++; $display("FAIL wr_n2_hs got=%b exp=11000", hs); end
      checks++; if (axi.axi_aw_addr_o !== 32'h100) begin failures++; $display("FAIL wr_awaddr got=%h exp=100", axi.axi_aw_addr_o); end
      checks++; if (axi.axi_aw_size_o !== 3'd3) begin failures++; $display("FAIL wr_awsize got=%0d exp=3", axi.axi_aw_size_o); end
      checks++; if (axi.axi_aw_len_o !== 8'd0) begin failures++; $display("FAIL wr_awlen got=%0d exp=0", axi.axi_aw_len_o); end
      checks++; if (axi.axi_aw_burst_o !== 2'b01) begin failures++; $display("FAIL wr_awburst got=%b exp=01", axi.axi_aw_burst_o); end
      checks++; if (axi.axi_w_data_o !== 64'hDEADBEEF_CAFEF00D) begin failures++; $display("FAIL wr_wdata got=%h exp=deadbeefcafef00d", axi.axi_w_data_o); end
      checks++; if (axi.axi_w_strb_o !== 8'hFF) begin failures++; $display("FAIL wr_wstrb got=%h exp=ff", axi.axi_w_strb_o); end
      checks++; if (axi.axi_w_last_o !== 1'b1) begin failures++; $display("FAIL wr_wlast got=%b exp=1", axi.axi_w_last_o); end
      step(); // N+3
      checks++; if (hs !== 5'b00100) begin failures++; $display("FAIL wr_n3_hs got=%b exp=00100", hs); end
      checks++; if (ah !== 2'b00) begin failures++; $display("FAIL wr_n3_ah got=%b exp=00", ah); end
      axi.axi_b_valid_i = 1'b1; axi.axi_b_resp_i = AXI_RESP_OKAY;
      step(); // N+4
      axi.axi_b_valid_i = 1'b0;
      checks++; if (ah !== 2'b10) begin failures++; $display("FAIL wr_n4_ah got=%b exp=10", ah); end
      checks++; if (hs !== 5'b00000) begin failures++; $display("FAIL wr_n4_hs got=%b exp=00000", hs); end
      step();
   endtask

   task automatic test_single_read();
      addr_phase(32'h208, 1'b0, 3'd3, HTRANS_NONSEQ);
      step(); // N+1
      bus_idle();
      checks++; if (hs !== 5'b00010) begin failures++; $display("FAIL rd_n1_hs got=%b exp=00010", hs); end
      checks++; if (axi.axi_ar_addr_o !== 32'h208) begin failures++; $display("FAIL rd_araddr got=%h exp=208", axi.axi_ar_addr_o); end
      checks++; if (ah !== 2'b00) begin failures++; $display("FAIL rd_n1_ah got=%b exp=00", ah); end
      step(); // N+2
      checks++; if (hs !== 5'b00001) begin failures++; $display("FAIL rd_n2_hs got=%b exp=00001", hs); end
      axi.axi_r_valid_i = 1'b1; axi.axi_r_data_i = 64'h1234;
      axi.axi_r_resp_i = AXI_RESP_OKAY; axi.axi_r_last_i = 1'b1;
      step(); // N+3
      axi.axi_r_valid_i = 1'b0; axi.axi_r_data_i = 64'hBAD0_BAD0;
      checks++; if (ah !== 2'b10) begin failures++; $display("FAIL rd_n3_ah got=%b exp=10", ah); end
      checks++; if (ahb.HRDATA !== 64'h1234) begin failures++; $display("FAIL rd_hrdata got=%h exp=1234", ahb.HRDATA); end
      step(); step();
      checks++; if (ahb.HRDATA !== 64'h1234) begin failures++; $display("FAIL rd_hold got=%h exp=1234", ahb.HRDATA); end
   endtask

   task automatic test_write_backpressure();
      axi.axi_aw_ready_i = 1'b0; axi.axi_w_ready_i = 1'b0;
      addr_phase(32'h40, 1'b1, 3'd3, HTRANS_NONSEQ);
      step(); // N+1
      bus_idle();
      ahb.HWDATA = 64'h0123_4567_89AB_CDEF;
      step(); // N+2
      checks++; if (hs !== 5'b11000) begin failures++; $display("FAIL bp_n2_hs got=%b exp=11000", hs); end
      step(); // N+3
      checks++; if (hs !== 5'b11000) begin failures++; $display("FAIL bp_n3_hs got=%b exp=11000", hs); end
      axi.axi_w_ready_i = 1'b1;
      step(); // N+4: W done, AW still pending
      axi.axi_w_ready_i = 1'b0;
      checks++; if (hs !== 5'b10000) begin failures++; $display("FAIL bp_n4_hs got=%b exp=10000", hs); end
      step(); // N+5
      checks++; if (hs !== 5'b10000) begin failures++; $display("FAIL bp_n5_hs got=%b exp=10000", hs); end
      axi.axi_aw_ready_i = 1'b1;
      step(); // N+6
      checks++; if (hs !== 5'b00100) begin failures++; $display("FAIL bp_n6_hs got=%b exp=00100", hs); end
      checks++; if (ah !== 2'b00) begin failures++; $display("FAIL bp_n6_ah got=%b exp=00", ah); end
      axi.axi_b_valid_i = 1'b1; axi.axi_b_resp_i = AXI_RESP_SLVERR;
      step(); // N+7
      axi.axi_b_valid_i = 1'b0; axi.axi_b_resp_i = AXI_RESP_OKAY;
      checks++; if (ah !== 2'b01) begin failures++; $display("FAIL bp_err1 got=%b exp=01", ah); end
      checks++; if (hs !== 5'b00000) begin failures++; $display("FAIL bp_err1_hs got=%b exp=00000", hs); end
      step(); // N+8
      checks++; if (ah !== 2'b11) begin failures++; $display("FAIL bp_err2 got=%b exp=11", ah); end
      step(); // N+9
      checks++; if (ah !== 2'b10) begin failures++; $display("FAIL bp_idle got=%b exp=10", ah); end
      axi.axi_w_ready_i = 1'b1;
   endtask

   task automatic test_pipelined_reads();
      int p = 0, done = 0, ar_cnt = 0, rd_cnt = 0, last_done = -1;
      logic pending = 1'b0, accept_now;
      addr_phase(32'h0, 1'b0, 3'd3, HTRANS_NONSEQ);
      for (int c = 0; c < 40 && done < 4; c++) begin
         if (pending && ahb.HREADYOUT) begin
            checks++;
            if (ahb.HRDATA !== 64'hA000 + 64'(done)) begin
               failures++; $display("FAIL pipe_hrdata%0d got=%h exp=%h", done, ahb.HRDATA, 64'hA000 + 64'(done));
            end
            done++; pending = 1'b0; last_done = c;
         end
         accept_now = ahb.HREADYOUT && (p < 4);
         if (accept_now) begin pending = 1'b1; p++; end
         if (axi.axi_ar_valid_o) begin
            checks++;
            if (axi.axi_ar_addr_o !== 32'(ar_cnt * 8)) begin
               failures++; $display("FAIL pipe_araddr%0d got=%h exp=%h", ar_cnt, axi.axi_ar_addr_o, 32'(ar_cnt * 8));
            end
            ar_cnt++;
         end
         axi.axi_r_valid_i = axi.axi_r_ready_o;
         axi.axi_r_data_i  = 64'hA000 + 64'(rd_cnt);
         axi.axi_r_resp_i  = (rd_cnt == 1) ? AXI_RESP_EXOKAY : AXI_RESP_OKAY;
         if (axi.axi_r_ready_o) rd_cnt++;
         step();
         if (accept_now) begin
            if (p < 4) addr_phase(32'(p * 8), 1'b0, 3'd3, HTRANS_SEQ);
            else bus_idle();
         end
      end
      axi.axi_r_valid_i = 1'b0;
      bus_idle();
      checks++; if (done !== 4) begin failures++; $display("FAIL pipe_done got=%0d exp=4", done); end
      checks++; if (ar_cnt !== 4) begin failures++; $display("FAIL pipe_ar_count got=%0d exp=4", ar_cnt); end
      checks++; if (last_done !== 12) begin failures++; $display("FAIL pipe_last_cycle got=%0d exp=12", last_done); end
      step();
   endtask

   task automatic test_byte_write();
      logic [31:0] ta [3] = '{32'h3, 32'h6, 32'h4};
      logic [2:0]  ts [3] = '{3'd0, 3'd1, 3'd2};
      logic [7:0]  tw [3] = '{8'h08, 8'hC0, 8'hF0};
      for (int i = 0; i < 3; i++) begin
         addr_phase(ta[i], 1'b1, ts[i], HTRANS_NONSEQ);
         step();
         bus_idle();
         ahb.HWDATA = 64'h1111_2222_3333_4444;
         step();
         checks++; if (axi.axi_w_strb_o !== tw[i]) begin failures++; $display("FAIL bw_strb%0d got=%h exp=%h", i, axi.axi_w_strb_o, tw[i]); end
         checks++; if (axi.axi_aw_size_o !== ts[i]) begin failures++; $display("FAIL bw_size%0d got=%0d exp=%0d", i, axi.axi_aw_size_o, ts[i]); end
         checks++; if (axi.axi_aw_addr_o !== ta[i]) begin failures++; $display("FAIL bw_addr%0d got=%h exp=%h", i, axi.axi_aw_addr_o, ta[i]); end
         step();
         axi.axi_b_valid_i = 1'b1; axi.axi_b_resp_i = AXI_RESP_OKAY;
         step();
         axi.axi_b_valid_i = 1'b0;
         checks++; if (ah !== 2'b10) begin failures++; $display("FAIL bw_done%0d got=%b exp=10", i, ah); end
         step();
      end
   endtask

   task automatic test_oversize();
      addr_phase(32'h0, 1'b1, 3'd4, HTRANS_NONSEQ);
      step(); // ERR1
      bus_idle();
      checks++; if (ah !== 2'b01) begin failures++; $display("FAIL os_err1 got=%b exp=01", ah); end
      checks++; if (hs !== 5'b00000) begin failures++; $display("FAIL os_err1_hs got=%b exp=00000", hs); end
      step(); // ERR2; a new request here must be dropped
      checks++; if (ah !== 2'b11) begin failures++; $display("FAIL os_err2 got=%b exp=11", ah); end
      addr_phase(32'h80, 1'b0, 3'd3, HTRANS_NONSEQ);
      step();
      bus_idle();
      checks++; if (ah !== 2'b10) begin failures++; $display("FAIL os_idle got=%b exp=10", ah); end
      checks++; if (hs !== 5'b00000) begin failures++; $display("FAIL os_ignored_hs got=%b exp=00000", hs); end
      step();
      checks++; if (hs !== 5'b00000) begin failures++; $display("FAIL os_quiet_hs got=%b exp=00000", hs); end
   endtask

   task automatic test_reset_mid();
      addr_phase(32'h200, 1'b1, 3'd3, HTRANS_NONSEQ);
      step();
      bus_idle();
      ahb.HWDATA = 64'h5555_AAAA_5555_AAAA;
      step(); step(); // WR_RESP
      checks++; if (hs !== 5'b00100) begin failures++; $display("FAIL rm_wresp_hs got=%b exp=00100", hs); end
      #2 rst = 1'b1;
      #1;
      checks++; if (ah !== 2'b10) begin failures++; $display("FAIL rm_async_ah got=%b exp=10", ah); end
      checks++; if (hs !== 5'b00000) begin failures++; $display("FAIL rm_async_hs got=%b exp=00000", hs); end
      step();
      rst = 1'b0;
      addr_phase(32'h300, 1'b1, 3'd3, HTRANS_NONSEQ);
      step();
      bus_idle();
      ahb.HWDATA = 64'h0F0F_0F0F_0F0F_0F0F;
      step();
      checks++; if (hs !== 5'b11000) begin failures++; $display("FAIL rm_wr_hs got=%b exp=11000", hs); end
      checks++; if (axi.axi_aw_addr_o !== 32'h300) begin failures++; $display("FAIL rm_awaddr got=%h exp=300", axi.axi_aw_addr_o); end
      checks++; if (axi.axi_w_data_o !== 64'h0F0F_0F0F_0F0F_0F0F) begin failures++; $display("FAIL rm_wdata got=%h exp=0f0f0f0f0f0f0f0f", axi.axi_w_data_o); end
      step();
      axi.axi_b_valid_i = 1'b1; axi.axi_b_resp_i = AXI_RESP_OKAY;
      step();
      axi.axi_b_valid_i = 1'b0;
      checks++; if (ah !== 2'b10) begin failures++; $display("FAIL rm_done got=%b exp=10", ah); end
      step();
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_single_read();
      test_write_backpressure();
      test_pipelined_reads();
      test_byte_write();
      test_oversize();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
